// File: rtl/uart_wb_master_bridge.sv
// uart_wb_master_bridge
//   Serial-to-Wishbone debug bridge. An 8N1 UART receiver collects command
//   frames from ser_rx, a Wishbone classic master issues one 32-bit bus cycle
//   per frame, and an 8N1 UART transmitter returns status or read data on
//   ser_tx.
//
//   Frame format: CMD, ADDR[31:24..7:0], and for writes DATA[31:24..7:0].
//     CMD 'W' (8'h57) = write, CMD 'R' (8'h52) = read, other CMDs are ignored.
//   Responses: write ok -> A5, read ok -> 4 data bytes MSB first, timeout -> EE.
//
// Ports
//   wb_clk_i  in   clock, rising edge
//   wb_rst_i  in   synchronous active-high reset
//   ser_rx    in   serial input (asynchronous, idle high)
//   ser_tx    out  serial output (idle high)
//   wb_adr_o  out  bus address
//   wb_dat_o  out  bus write data
//   wb_sel_o  out  byte selects (always 4'hF)
//   wb_we_o   out  write enable
//   wb_cyc_o  out  bus cycle
//   wb_stb_o  out  strobe (mirrors wb_cyc_o)
//   wb_ack_i  in   responder acknowledge
//   wb_dat_i  in   responder read data
//   busy      out  high from accepted CMD until the last response stop bit ends
module uart_wb_master_bridge #(
  parameter logic [15:0] CLK_DIV     = 16'd434,
  parameter logic [15:0] BUS_TIMEOUT = 16'd1023,
  parameter logic [23:0] RX_TIMEOUT  = 24'd500000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RSEND, S_RWAIT} state_e;

  localparam logic [7:0]  CMD_WR   = 8'h57;
  localparam logic [7:0]  CMD_RD   = 8'h52;
  localparam logic [7:0]  RSP_OK   = 8'hA5;
  localparam logic [7:0]  RSP_ERR  = 8'hEE;
  localparam logic [15:0] HALF_DIV = CLK_DIV >> 1;

  logic        rx_p0, rx_p1, rx_p2;
  rx_state_e   rx_st;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sr;
  logic        rx_vld;
  logic        rx_ferr;

  logic        tx_act;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_n;
  logic [8:0]  tx_sr;
  logic        tx_start;
  logic        tx_done;

  state_e      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic        is_wr;
  logic        err;
  logic [1:0]  resp_idx;
  logic [15:0] bus_cnt;
  logic [23:0] idle_cnt;
  logic [31:0] rd_data;
  logic [7:0]  resp_byte;
  logic        resp_last;

  // ---- stage p0..p2: ser_rx synchronizer, p2 keeps the previous level for edge detect
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= ser_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // ---- UART receive: half-bit start check, then one sample per bit period
  always_ff @(posedge wb_clk_i) begin
    rx_vld  <= 1'b0;
    rx_ferr <= 1'b0;
    if (wb_rst_i) begin
      rx_st  <= RX_IDLE;
      rx_cnt <= 16'd0;
      rx_bit <= 3'd0;
    end else begin
      case (rx_st)
        RX_IDLE: begin
          rx_cnt <= 16'd0;
          if (rx_p2 && !rx_p1) rx_st <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_DIV - 16'd1) begin
            rx_cnt <= 16'd0;
            rx_bit <= 3'd0;
            // line back high at mid start bit: treat as a glitch
            rx_st  <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CLK_DIV - 16'd1) begin
            rx_cnt <= 16'd0;
            rx_sr  <= {rx_p1, rx_sr[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CLK_DIV - 16'd1) begin
            rx_cnt  <= 16'd0;
            rx_st   <= RX_IDLE;
            rx_vld  <= rx_p1;
            rx_ferr <= !rx_p1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---- UART transmit: tx_sr holds {stop, data}; start bit is driven on load
  assign tx_done = tx_act && (tx_cnt == CLK_DIV - 16'd1) && (tx_n == 4'd9);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_act <= 1'b0;
      tx_cnt <= 16'd0;
      tx_n   <= 4'd0;
      ser_tx <= 1'b1;
    end else if (!tx_act) begin
      if (tx_start) begin
        tx_act <= 1'b1;
        tx_sr  <= {1'b1, resp_byte};
        tx_cnt <= 16'd0;
        tx_n   <= 4'd0;
        ser_tx <= 1'b0;
      end
    end else if (tx_cnt == CLK_DIV - 16'd1) begin
      tx_cnt <= 16'd0;
      if (tx_n == 4'd9) begin
        tx_act <= 1'b0;
        ser_tx <= 1'b1;
      end else begin
        ser_tx <= tx_sr[0];
        tx_sr  <= {1'b1, tx_sr[8:1]};
        tx_n   <= tx_n + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  // ---- frame FSM: state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // ---- frame FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_vld && (rx_sr == CMD_WR || rx_sr == CMD_RD)) state_nxt = S_ADDR;
      end
      S_ADDR, S_DATA: begin
        if (rx_ferr) begin
          state_nxt = S_IDLE;
        end else if (rx_vld) begin
          if (byte_cnt == 2'd3) state_nxt = (state == S_ADDR && is_wr) ? S_DATA : S_BUS;
        end else if (idle_cnt >= RX_TIMEOUT) begin
          state_nxt = S_IDLE;
        end
      end
      S_BUS: begin
        if (wb_ack_i || bus_cnt >= BUS_TIMEOUT) state_nxt = S_RSEND;
      end
      S_RSEND: state_nxt = S_RWAIT;
      S_RWAIT: begin
        if (tx_done) state_nxt = resp_last ? S_IDLE : S_RSEND;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- frame FSM: outputs
  always_comb begin
    wb_cyc_o = (state == S_BUS);
    wb_stb_o = (state == S_BUS);
    wb_we_o  = (state == S_BUS) && is_wr;
    tx_start = (state == S_RSEND);
    busy     = (state != S_IDLE);
  end

  assign wb_sel_o = 4'hF;

  // ---- frame datapath: address/data assembly, counters, status
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_adr_o <= 32'd0;
      wb_dat_o <= 32'd0;
      byte_cnt <= 2'd0;
      is_wr    <= 1'b0;
      err      <= 1'b0;
      resp_idx <= 2'd0;
      bus_cnt  <= 16'd0;
      idle_cnt <= 24'd0;
    end else begin
      bus_cnt <= (state == S_BUS) ? bus_cnt + 16'd1 : 16'd0;
      case (state)
        S_IDLE: begin
          byte_cnt <= 2'd0;
          idle_cnt <= 24'd0;
          err      <= 1'b0;
          resp_idx <= 2'd0;
          if (rx_vld) is_wr <= (rx_sr == CMD_WR);
        end
        S_ADDR: begin
          if (rx_vld) begin
            wb_adr_o <= {wb_adr_o[23:0], rx_sr};
            byte_cnt <= byte_cnt + 2'd1;
            idle_cnt <= 24'd0;
          end else begin
            idle_cnt <= idle_cnt + 24'd1;
          end
        end
        S_DATA: begin
          if (rx_vld) begin
            wb_dat_o <= {wb_dat_o[23:0], rx_sr};
            byte_cnt <= byte_cnt + 2'd1;
            idle_cnt <= 24'd0;
          end else begin
            idle_cnt <= idle_cnt + 24'd1;
          end
        end
        S_BUS: begin
          if (!wb_ack_i && bus_cnt >= BUS_TIMEOUT) err <= 1'b1;
        end
        S_RWAIT: begin
          if (tx_done) resp_idx <= resp_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (state == S_BUS && wb_ack_i) rd_data <= wb_dat_i;
  end

  // ---- response byte select
  always_comb begin
    resp_byte = rd_data[31:24];
    case (resp_idx)
      2'd1:    resp_byte = rd_data[23:16];
      2'd2:    resp_byte = rd_data[15:8];
      2'd3:    resp_byte = rd_data[7:0];
      default: resp_byte = rd_data[31:24];
    endcase
    if (is_wr) resp_byte = RSP_OK;
    if (err)   resp_byte = RSP_ERR;
  end

  assign resp_last = err | is_wr | (resp_idx == 2'd3);

endmodule
